// File: rtl/riscv_mem_sequencer.sv
// Memory-port sequencer for the RISCV core: configure, load images, run, dump data memory.
module riscv_mem_sequencer #(
  parameter int unsigned SIZE_TEXT      = 1024,
  parameter int unsigned SIZE_DATA      = 1792,
  parameter int unsigned SIZE_STACK     = 256,
  parameter logic [31:0] TEXT_BASE      = 32'h00010000,
  parameter logic [31:0] STACK_TOP      = 32'hbffffff4,
  parameter int unsigned MAX_RUN_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] eof_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_inst_i,
  input  logic [31:0] in_data_i,
  output logic [1:0]  src_o,
  output logic [31:0] a_I_o,
  output logic [31:0] a_D_o,
  output logic [31:0] d_I_o,
  output logic [31:0] d_D_o,
  output logic        core_rst_o,
  input  logic [31:0] q_i,
  input  logic [31:0] det_a_i,
  output logic        dump_valid_o,
  input  logic        dump_ready_i,
  output logic [31:0] dump_data_o,
  output logic [10:0] dump_idx_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o
);

  localparam int unsigned IDX_W = 11;
  localparam int unsigned CNT_W = 15;
  localparam logic [31:0] TEXT_END   = TEXT_BASE + 32'(4 * SIZE_TEXT);
  localparam logic [31:0] TEXT_CFG   = TEXT_BASE + 32'(2 * SIZE_TEXT);
  localparam logic [31:0] STACK_BASE = STACK_TOP - 32'(4 * SIZE_STACK);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SIZE_DATA - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_RUN_CYCLES - 1);

  localparam logic [1:0] SRC_RUN  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_READ = 2'b10;
  localparam logic [1:0] SRC_CFG  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_LOAD, S_RUN, S_DRAIN,
    S_DUMP_ADDR, S_DUMP_WAIT, S_DUMP_OUT, S_DONE, S_TIMEOUT
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      eof_q, eof_d;
  logic [IDX_W-1:0] beat_q, beat_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic        in_ready_d, core_rst_d, dump_valid_d, busy_d, done_d, timeout_d;
  logic [1:0]  src_d;
  logic [31:0] a_i_d, a_d_d, d_i_d, d_d_d, dump_data_d;
  logic [10:0] dump_idx_d;
  logic [31:0] data_base;

  // Data image origin: the data region starts 8 bytes below the program end.
  assign data_base = eof_q - 32'd8;

  // Next-state and next-output computation; outputs register together with the state.
  always_comb begin
    state_d      = state_q;
    eof_d        = eof_q;
    beat_d       = beat_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    in_ready_d   = in_ready_o;
    src_d        = src_o;
    a_i_d        = a_I_o;
    a_d_d        = a_D_o;
    d_i_d        = d_I_o;
    d_d_d        = d_D_o;
    core_rst_d   = core_rst_o;
    dump_valid_d = dump_valid_o;
    dump_data_d  = dump_data_o;
    dump_idx_d   = dump_idx_o;
    busy_d       = busy_o;
    done_d       = done_o;
    timeout_d    = timeout_o;

    unique case (state_q)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (start_i) begin
          state_d    = S_CFG;
          eof_d      = eof_i;
          done_d     = 1'b0;
          timeout_d  = 1'b0;
          busy_d     = 1'b1;
          src_d      = SRC_CFG;
          core_rst_d = 1'b1;
          a_i_d      = TEXT_BASE;
          d_i_d      = TEXT_CFG;
          a_d_d      = eof_i - 32'd8;
          d_d_d      = STACK_BASE;
        end
      end
      S_CFG: begin
        state_d    = S_LOAD;
        beat_d     = '0;
        last_d     = 1'b0;
        in_ready_d = 1'b1;
        src_d      = SRC_RUN;
      end
      S_LOAD: begin
        src_d = SRC_RUN;
        if (last_q) begin
          // Final beat's write cycle has just completed: release the core.
          state_d    = S_RUN;
          cnt_d      = '0;
          core_rst_d = 1'b0;
          a_i_d      = TEXT_BASE;
          a_d_d      = data_base;
          d_i_d      = '0;
          d_d_d      = '0;
        end else if (in_valid_i && in_ready_o) begin
          src_d = SRC_LOAD;
          a_d_d = data_base + (32'(beat_q) << 2);
          d_d_d = in_data_i;
          if (32'(beat_q) < SIZE_TEXT) begin
            a_i_d = TEXT_BASE + (32'(beat_q) << 2);
            d_i_d = in_inst_i;
          end else begin
            a_i_d = TEXT_END;
            d_i_d = '0;
          end
          beat_d = beat_q + IDX_W'(1);
          if (beat_q == IDX_LAST) begin
            last_d     = 1'b1;
            in_ready_d = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (det_a_i >= eof_q) begin
          state_d = S_DRAIN;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = S_TIMEOUT;
          timeout_d  = 1'b1;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          core_rst_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        state_d    = S_DUMP_ADDR;
        idx_d      = '0;
        core_rst_d = 1'b1;
        src_d      = SRC_READ;
        a_d_d      = data_base;
      end
      S_DUMP_ADDR: begin
        state_d = S_DUMP_WAIT;
      end
      S_DUMP_WAIT: begin
        state_d      = S_DUMP_OUT;
        dump_data_d  = q_i;
        dump_idx_d   = idx_q;
        dump_valid_d = 1'b1;
      end
      S_DUMP_OUT: begin
        if (dump_ready_i) begin
          dump_valid_d = 1'b0;
          if (idx_q == IDX_LAST) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            src_d      = SRC_RUN;
            core_rst_d = 1'b1;
          end else begin
            state_d = S_DUMP_ADDR;
            idx_d   = idx_q + IDX_W'(1);
            a_d_d   = data_base + (32'(idx_q + IDX_W'(1)) << 2);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      eof_q        <= '0;
      beat_q       <= '0;
      last_q       <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      in_ready_o   <= 1'b0;
      src_o        <= SRC_RUN;
      a_I_o        <= '0;
      a_D_o        <= '0;
      d_I_o        <= '0;
      d_D_o        <= '0;
      core_rst_o   <= 1'b1;
      dump_valid_o <= 1'b0;
      dump_data_o  <= '0;
      dump_idx_o   <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      state_q      <= state_d;
      eof_q        <= eof_d;
      beat_q       <= beat_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      in_ready_o   <= in_ready_d;
      src_o        <= src_d;
      a_I_o        <= a_i_d;
      a_D_o        <= a_d_d;
      d_I_o        <= d_i_d;
      d_D_o        <= d_d_d;
      core_rst_o   <= core_rst_d;
      dump_valid_o <= dump_valid_d;
      dump_data_o  <= dump_data_d;
      dump_idx_o   <= dump_idx_d;
      busy_o       <= busy_d;
      done_o       <= done_d;
      timeout_o    <= timeout_d;
    end
  end

endmodule

// File: tb/tb_riscv_mem_sequencer.sv
// Directed bench for riscv_mem_sequencer: load, run, dump, timeout and mid-load reset.
module tb_riscv_mem_sequencer;

  localparam logic [31:0] TB_BASE = 32'h00010000;
  localparam logic [31:0] E1      = 32'h00010040;
  localparam logic [31:0] E2      = 32'h00020000;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, dump_ready, store_req;
  logic [31:0] eof, in_inst, in_data, det_a, q;
  logic [31:0] det_zero = 32'h0;
  logic [31:0] base_addr = E1 - 32'd8;

  logic        in_ready, core_rst, dump_valid, busy, done, timeout;
  logic [1:0]  src;
  logic [31:0] a_i, a_d, d_i, d_d, dump_data;
  logic [10:0] dump_idx;

  logic        to_in_ready, to_core_rst, to_dump_valid, to_busy, to_done, to_timeout;
  logic [1:0]  to_src;
  logic [31:0] to_a_i, to_a_d, to_d_i, to_d_d, to_dump_data;
  logic [10:0] to_dump_idx;
  logic        to_dump_seen = 1'b0;

  logic [31:0] mem [8];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  riscv_mem_sequencer #(.SIZE_TEXT(4), .SIZE_DATA(6), .MAX_RUN_CYCLES(200)) dut (
    .clk(clk), .rst(rst), .start_i(start), .eof_i(eof),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_inst_i(in_inst), .in_data_i(in_data),
    .src_o(src), .a_I_o(a_i), .a_D_o(a_d), .d_I_o(d_i), .d_D_o(d_d),
    .core_rst_o(core_rst), .q_i(q), .det_a_i(det_a),
    .dump_valid_o(dump_valid), .dump_ready_i(dump_ready), .dump_data_o(dump_data),
    .dump_idx_o(dump_idx), .busy_o(busy), .done_o(done), .timeout_o(timeout));

  riscv_mem_sequencer #(.SIZE_TEXT(4), .SIZE_DATA(6), .MAX_RUN_CYCLES(50)) dut_to (
    .clk(clk), .rst(rst), .start_i(start), .eof_i(eof),
    .in_valid_i(in_valid), .in_ready_o(to_in_ready), .in_inst_i(in_inst), .in_data_i(in_data),
    .src_o(to_src), .a_I_o(to_a_i), .a_D_o(to_a_d), .d_I_o(to_d_i), .d_D_o(to_d_d),
    .core_rst_o(to_core_rst), .q_i(q), .det_a_i(det_zero),
    .dump_valid_o(to_dump_valid), .dump_ready_i(dump_ready), .dump_data_o(to_dump_data),
    .dump_idx_o(to_dump_idx), .busy_o(to_busy), .done_o(to_done), .timeout_o(to_timeout));

  function automatic logic [31:0] inst_w(input int k);
    return 32'h13000000 | 32'(k);
  endfunction

  function automatic logic [31:0] data_w(input int k);
    return 32'hD0000000 + 32'(k) * 32'h111;
  endfunction

  function automatic logic [31:0] dump_w(input int k);
    return (k == 1) ? 32'hCAFEF00D : data_w(k);
  endfunction

  function automatic logic in_win(input logic [31:0] a);
    return (a >= base_addr) && ((a - base_addr) < 32'd32);
  endfunction

  // Core data-memory model: write on load strobe, 1-cycle read latency.
  always @(posedge clk) begin
    q <= in_win(a_d) ? mem[3'((a_d - base_addr) >> 2)] : 32'hDEADBEEF;
    if (src == 2'b01 && in_win(a_d)) mem[3'((a_d - base_addr) >> 2)] <= d_d;
    if (store_req) mem[1] <= 32'hCAFEF00D;
    if (to_dump_valid) to_dump_seen <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_src"}, 32'(src), 32'd0);
    check({pfx, "_a_i"}, a_i, 32'd0);
    check({pfx, "_a_d"}, a_d, 32'd0);
    check({pfx, "_d_i"}, d_i, 32'd0);
    check({pfx, "_d_d"}, d_d, 32'd0);
    check({pfx, "_core_rst"}, 32'(core_rst), 32'd1);
    check({pfx, "_in_ready"}, 32'(in_ready), 32'd0);
    check({pfx, "_dump_valid"}, 32'(dump_valid), 32'd0);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
    check({pfx, "_done"}, 32'(done), 32'd0);
    check({pfx, "_timeout"}, 32'(timeout), 32'd0);
    check({pfx, "_to_done"}, 32'(to_done), 32'd0);
    check({pfx, "_to_timeout"}, 32'(to_timeout), 32'd0);
  endtask

  initial begin
    int prev_acc, nacc, nwr, to_first, exp_idx, stall;
    rst = 1'b1; start = 1'b0; eof = E1; in_valid = 1'b0; in_inst = '0; in_data = '0;
    det_a = '0; dump_ready = 1'b1; store_req = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("reset");

    // Session 1: start, one config cycle.
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1; eof = E1;
    @(negedge clk);
    check("cfg_src", 32'(src), 32'd3);
    check("cfg_a_i", a_i, TB_BASE);
    check("cfg_d_i", d_i, 32'h00010008);
    check("cfg_a_d", a_d, 32'h00010038);
    check("cfg_d_d", d_d, 32'hbffffbf4);
    check("cfg_core_rst", 32'(core_rst), 32'd1);
    check("cfg_busy", 32'(busy), 32'd1);
    check("cfg_in_ready", 32'(in_ready), 32'd0);
    start = 1'b0;
    @(negedge clk);

    // Load with in_valid on every other cycle.
    prev_acc = 0; nacc = 0; nwr = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (core_rst == 1'b0) break;
      check("load_core_rst", 32'(core_rst), 32'd1);
      check("load_in_ready", 32'(in_ready), (nacc < 6) ? 32'd1 : 32'd0);
      check("load_src", 32'(src), (prev_acc != 0) ? 32'd1 : 32'd0);
      if (src == 2'b01) begin
        check("load_a_d", a_d, E1 - 32'd8 + 32'(4 * nwr));
        check("load_d_d", d_d, data_w(nwr));
        check("load_a_i", a_i, (nwr < 4) ? TB_BASE + 32'(4 * nwr) : TB_BASE + 32'd16);
        check("load_d_i", d_i, (nwr < 4) ? inst_w(nwr) : 32'd0);
        nwr++;
      end
      in_valid = ((cyc % 2) == 0) && (nacc < 6);
      in_inst = inst_w(nacc);
      in_data = data_w(nacc);
      prev_acc = (in_valid && in_ready) ? 1 : 0;
      if (prev_acc != 0) nacc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("run0_core_rst", 32'(core_rst), 32'd0);
    check("load_writes", 32'(nwr), 32'd6);
    check("run0_src", 32'(src), 32'd0);
    check("run0_a_i", a_i, TB_BASE);
    check("run0_a_d", a_d, E1 - 32'd8);
    check("run0_d_d", d_d, 32'd0);
    check("run0_in_ready", 32'(in_ready), 32'd0);

    // Run: completion at run cycle 100; stray start/in_valid must be ignored.
    to_first = -1;
    for (int c = 0; c <= 100; c++) begin
      check("run_core_rst", 32'(core_rst), 32'd0);
      check("run_src", 32'(src), 32'd0);
      if (to_timeout && to_first < 0) to_first = c;
      store_req = (c == 50);
      start = (c == 20);
      eof = (c == 20) ? 32'h00000010 : E1;
      in_valid = (c == 30);
      if (c == 100) det_a = E1;
      @(negedge clk);
    end
    store_req = 1'b0; start = 1'b0; in_valid = 1'b0; eof = E1;
    check("drain_core_rst", 32'(core_rst), 32'd0);
    check("drain_src", 32'(src), 32'd0);
    check("to_cycle", 32'(to_first), 32'd50);
    check("to_timeout", 32'(to_timeout), 32'd1);
    check("to_done", 32'(to_done), 32'd1);
    check("to_busy", 32'(to_busy), 32'd0);
    check("to_core_rst", 32'(to_core_rst), 32'd1);
    @(negedge clk);
    det_a = '0;
    check("dump_addr_src", 32'(src), 32'd2);
    check("dump_addr_core_rst", 32'(core_rst), 32'd1);
    check("dump_addr_a_d", a_d, E1 - 32'd8);
    check("dump_addr_valid", 32'(dump_valid), 32'd0);

    // Dump with a 5-cycle stall on word 2.
    exp_idx = 0; stall = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      check("dump_core_rst", 32'(core_rst), 32'd1);
      if (dump_valid) begin
        check("dump_idx", 32'(dump_idx), 32'(exp_idx));
        check("dump_data", dump_data, dump_w(exp_idx));
        if (exp_idx == 2 && stall < 5) begin
          dump_ready = 1'b0;
          stall++;
        end else begin
          dump_ready = 1'b1;
        end
        if (dump_ready) exp_idx++;
      end else begin
        dump_ready = 1'b1;
      end
      @(negedge clk);
    end
    check("done_flag", 32'(done), 32'd1);
    check("dump_count", 32'(exp_idx), 32'd6);
    check("dump_stall", 32'(stall), 32'd5);
    check("done_busy", 32'(busy), 32'd0);
    check("done_valid", 32'(dump_valid), 32'd0);
    check("done_timeout", 32'(timeout), 32'd0);
    check("done_src", 32'(src), 32'd0);
    check("done_core_rst", 32'(core_rst), 32'd1);
    check("to_never_dumped", 32'(to_dump_seen), 32'd0);

    // Session 2: restart from DONE/TIMEOUT, reset mid-load at beat 3.
    start = 1'b1; eof = E2;
    @(negedge clk);
    start = 1'b0;
    check("s2_cfg_done", 32'(done), 32'd0);
    check("s2_cfg_busy", 32'(busy), 32'd1);
    check("s2_cfg_a_d", a_d, E2 - 32'd8);
    check("s2_to_timeout", 32'(to_timeout), 32'd0);
    check("s2_to_src", 32'(to_src), 32'd3);
    in_valid = 1'b1; in_inst = inst_w(0); in_data = data_w(0);
    @(negedge clk);
    in_inst = inst_w(1); in_data = data_w(1);
    @(negedge clk);
    check("s2_write0_a_d", a_d, E2 - 32'd8);
    in_inst = inst_w(2); in_data = data_w(2);
    @(negedge clk);
    check("s2_write1_a_d", a_d, E2 - 32'd4);
    in_inst = inst_w(3); in_data = data_w(3);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midload_reset");

    // Reload restarts at beat 0.
    rst = 1'b0; in_valid = 1'b0; start = 1'b1; eof = E1;
    @(negedge clk);
    start = 1'b0;
    check("s3_cfg_src", 32'(src), 32'd3);
    check("s3_cfg_a_d", a_d, E1 - 32'd8);
    in_valid = 1'b1; in_inst = inst_w(0); in_data = data_w(0);
    @(negedge clk);
    check("s3_load0_src", 32'(src), 32'd0);
    check("s3_load0_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("s3_write0_src", 32'(src), 32'd1);
    check("s3_write0_a_d", a_d, E1 - 32'd8);
    check("s3_write0_a_i", a_i, TB_BASE);
    check("s3_write0_d_d", d_d, data_w(0));
    check("s3_write0_d_i", d_i, inst_w(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
